// File: rtl/softusb_pkg.sv
// Shared definitions for the SoftUSB data memory: Wishbone cycle types,
// the Wishbone-side FSM encoding and a constant log2 helper.
package softusb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } wb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/softusb_dpram_be.sv
// One byte lane of the data memory: single-clock true dual-port 8-bit RAM,
// read-first on both ports, with per-port read enables.
module softusb_dpram_be #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en_a_i,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [7:0]    di_a_i,
  output logic [7:0]    do_a_o,
  input  logic          en_b_i,
  input  logic          we_b_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [7:0]    di_b_i,
  output logic [7:0]    do_b_o
);

  logic [7:0] mem_q [0:(1<<AW)-1];

  // Reads sample the array before this edge's writes land, so both ports
  // (and cross-port accesses) see the old contents.
  always_ff @(posedge clk) begin
    if (en_a_i) do_a_o <= mem_q[addr_a_i];
    if (en_b_i) do_b_o <= mem_q[addr_b_i];
    if (we_a_i) mem_q[addr_a_i] <= di_a_i;
    if (we_b_i) mem_q[addr_b_i] <= di_b_i;
  end

endmodule

// File: rtl/softusb_dmem_ctl.sv
// SoftUSB data memory: Wishbone slave (wait states, incrementing bursts) and an
// 8-bit microcontroller port sharing byte-banked dual-port RAM.
module softusb_dmem_ctl
  import softusb_pkg::*;
#(
  parameter int adr_width   = 11,
  parameter int lanes       = 4,
  parameter int big_endian  = 1,
  parameter int wait_states = 0
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst_n,
  input  logic [31:0]                         wb_adr_i,
  input  logic [8*lanes-1:0]                  wb_dat_i,
  output logic [8*lanes-1:0]                  wb_dat_o,
  input  logic [lanes-1:0]                    wb_sel_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_cyc_i,
  input  logic                                wb_we_i,
  input  logic [2:0]                          wb_cti_i,
  output logic                                wb_ack_o,
  input  logic [adr_width+clog2(lanes)-1:0]   cpu_a,
  input  logic                                cpu_re,
  input  logic                                cpu_we,
  input  logic [7:0]                          cpu_di,
  output logic [7:0]                          cpu_do,
  output logic [15:0]                         collision_cnt
);

  localparam int LB = clog2(lanes);
  localparam int LW = (LB > 0) ? LB : 1;
  localparam int DW = 8 * lanes;

  wb_state_e            state_q, state_d;
  logic [adr_width-1:0] cnt_q, cnt_d;
  logic [1:0]           ws_q, ws_d;
  logic                 burst_q, burst_d;
  logic [DW-1:0]        dat_q;
  logic                 ack;
  logic [adr_width-1:0] wb_word, cnt_inc, ram_addr_a;
  logic [DW-1:0]        ram_rd_a;
  logic [lanes-1:0]     wb_we_lane, coll_lane;

  logic [LW-1:0]        cpu_lane, lane_q;
  logic [adr_width-1:0] cpu_word;
  logic [7:0]           ram_rd_b [lanes];
  logic                 rd_seen_q;
  logic [15:0]          coll_cnt_q;
  logic                 unused_adr;

  assign wb_word    = wb_adr_i[adr_width+LB-1:LB];
  assign cnt_inc    = cnt_q + adr_width'(1);
  assign unused_adr = ^wb_adr_i;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ws_q    <= '0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ws_d    = ws_q;
    burst_d = burst_q;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_stb_i && wb_cyc_i) begin
          cnt_d   = wb_word;
          burst_d = (wb_cti_i == CTI_INCR);
          ws_d    = 2'(wait_states);
          if (wait_states == 0) state_d = burst_d ? ST_BURST : ST_ACK;
          else                  state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i)          state_d = ST_IDLE;
        else if (ws_q == 2'd1)  state_d = burst_q ? ST_BURST : ST_ACK;
        else                    ws_d = ws_q - 2'd1;
      end
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wb_stb_i) begin
          ack   = 1'b1;
          cnt_d = cnt_inc;
          if (wb_cti_i == CTI_END) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read one word ahead while acking a read burst so the next beat's data is
  // already registered; writes always land at the current counter.
  always_comb begin
    if (state_q == ST_IDLE)                          ram_addr_a = wb_word;
    else if (ack && state_q == ST_BURST && !wb_we_i) ram_addr_a = cnt_inc;
    else                                             ram_addr_a = cnt_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  dat_q <= '0;
    else if (ack)    dat_q <= ram_rd_a;
  end

  assign wb_ack_o = ack;
  assign wb_dat_o = ack ? ram_rd_a : dat_q;

  generate
    if (lanes == 1) begin : g_one_lane
      assign cpu_lane = '0;
      assign cpu_word = cpu_a;
    end else begin : g_multi_lane
      logic [LB-1:0] cpu_off;
      assign cpu_off  = cpu_a[LB-1:0];
      assign cpu_lane = (big_endian != 0) ? ~cpu_off : cpu_off;
      assign cpu_word = cpu_a[adr_width+LB-1:LB];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
      logic cpu_hit;
      assign cpu_hit        = cpu_we && (cpu_lane == LW'(gi));
      assign wb_we_lane[gi] = ack && wb_we_i && wb_sel_i[gi];
      // WB wins a same-byte write race; the CPU byte is dropped and counted.
      assign coll_lane[gi]  = cpu_hit && wb_we_lane[gi] && (cpu_word == cnt_q);

      softusb_dpram_be #(.AW(adr_width)) u_ram (
        .clk      (sys_clk),
        .en_a_i   (1'b1),
        .we_a_i   (wb_we_lane[gi]),
        .addr_a_i (ram_addr_a),
        .di_a_i   (wb_dat_i[8*gi +: 8]),
        .do_a_o   (ram_rd_a[8*gi +: 8]),
        .en_b_i   (cpu_re),
        .we_b_i   (cpu_hit && !coll_lane[gi]),
        .addr_b_i (cpu_word),
        .di_b_i   (cpu_di),
        .do_b_o   (ram_rd_b[gi])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lane_q    <= '0;
      rd_seen_q <= 1'b0;
    end else if (cpu_re) begin
      lane_q    <= cpu_lane;
      rd_seen_q <= 1'b1;
    end
  end

  assign cpu_do = rd_seen_q ? ram_rd_b[lane_q] : 8'h00;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                coll_cnt_q <= '0;
    else if ((|coll_lane) && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
  end

  assign collision_cnt = coll_cnt_q;

endmodule

// File: tb/tb_softusb_dmem_ctl.sv
// Directed bench for softusb_dmem_ctl: default build, a wait_states=2 build and
// a little-endian two-lane build share one clock and reset.
module tb_softusb_dmem_ctl;
  import softusb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default build
  logic [31:0] adr0, dati0, dato0;
  logic [3:0]  sel0;
  logic        stb0, cyc0, we0, ack0;
  logic [2:0]  cti0;
  logic [12:0] ca0;
  logic        cre0, cwe0;
  logic [7:0]  cdi0, cdo0;
  logic [15:0] coll0;

  // wait_states = 2 build
  logic [31:0] adr1, dati1, dato1;
  logic [3:0]  sel1;
  logic        stb1, cyc1, we1, ack1;
  logic [2:0]  cti1;
  logic [12:0] ca1;
  logic        cre1, cwe1;
  logic [7:0]  cdi1, cdo1;
  logic [15:0] coll1;

  // lanes = 2, little-endian build
  logic [31:0] adr2;
  logic [15:0] dati2, dato2;
  logic [1:0]  sel2;
  logic        stb2, cyc2, we2, ack2;
  logic [2:0]  cti2;
  logic [4:0]  ca2;
  logic        cre2, cwe2;
  logic [7:0]  cdi2, cdo2;
  logic [15:0] coll2;

  softusb_dmem_ctl dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr0), .wb_dat_i(dati0), .wb_dat_o(dato0),
    .wb_sel_i(sel0), .wb_stb_i(stb0), .wb_cyc_i(cyc0), .wb_we_i(we0), .wb_cti_i(cti0),
    .wb_ack_o(ack0), .cpu_a(ca0), .cpu_re(cre0), .cpu_we(cwe0), .cpu_di(cdi0),
    .cpu_do(cdo0), .collision_cnt(coll0)
  );

  softusb_dmem_ctl #(.wait_states(2)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr1), .wb_dat_i(dati1), .wb_dat_o(dato1),
    .wb_sel_i(sel1), .wb_stb_i(stb1), .wb_cyc_i(cyc1), .wb_we_i(we1), .wb_cti_i(cti1),
    .wb_ack_o(ack1), .cpu_a(ca1), .cpu_re(cre1), .cpu_we(cwe1), .cpu_di(cdi1),
    .cpu_do(cdo1), .collision_cnt(coll1)
  );

  softusb_dmem_ctl #(.adr_width(4), .lanes(2), .big_endian(0), .wait_states(0)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr2), .wb_dat_i(dati2), .wb_dat_o(dato2),
    .wb_sel_i(sel2), .wb_stb_i(stb2), .wb_cyc_i(cyc2), .wb_we_i(we2), .wb_cti_i(cti2),
    .wb_ack_o(ack2), .cpu_a(ca2), .cpu_re(cre2), .cpu_we(cwe2), .cpu_di(cdi2),
    .cpu_do(cdo2), .collision_cnt(coll2)
  );

  // Classic cycle on dut0; lat counts clock cycles from stb to ack (20 = no ack).
  task automatic wb0_classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    adr0 = a; we0 = w; dati0 = d; sel0 = s; cti0 = CTI_CLASSIC; stb0 = 1'b1; cyc0 = 1'b1;
    lat = 0;
    rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0) begin
        rd = dato0;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    stb0 = 1'b0; cyc0 = 1'b0; we0 = 1'b0;
    $display("wb classic adr=%h we=%0d lat=%0d rd=%h", a, w, lat, rd);
  endtask

  task automatic cpu0_read(input logic [12:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    ca0 = a; cre0 = 1'b1;
    @(posedge clk); #1;
    cre0 = 1'b0;
    @(negedge clk);
    d = cdo0;
    $display("cpu read a=%h do=%h", a, d);
  endtask

  // Read burst on dut0; cycle c (1..n) drives stb=stbp[c-1], cti=111 on cycle n.
  task automatic run_burst0(input logic [31:0] a, input logic [7:0] stbp, input int n,
                            output logic [7:0] ackv, output logic [255:0] dv);
    @(posedge clk); #1;
    adr0 = a; we0 = 1'b0; cti0 = CTI_INCR; stb0 = 1'b1; cyc0 = 1'b1;
    ackv = '0;
    dv = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      stb0 = stbp[c-1];
      cti0 = (c == n) ? CTI_END : CTI_INCR;
      @(negedge clk);
      ackv[c-1] = ack0;
      dv[32*(c-1) +: 32] = dato0;
    end
    @(posedge clk); #1;
    stb0 = 1'b0; cyc0 = 1'b0; cti0 = CTI_CLASSIC;
    @(negedge clk);
    ackv[n] = ack0;
    $display("wb burst adr=%h acks=%b", a, ackv);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ack0); end
    checks++; if (dato0 !== 32'h0) begin errors++; $display("FAIL rst_dat got %h want 0", dato0); end
    checks++; if (cdo0 !== 8'h00) begin errors++; $display("FAIL rst_cpu_do got %h want 00", cdo0); end
    checks++; if (coll0 !== 16'h0) begin errors++; $display("FAIL rst_coll got %h want 0", coll0); end
  endtask

  task automatic test_classic;
    logic [31:0] rd;
    int lat;
    logic [7:0] b;
    logic [31:0] word;
    wb0_classic(32'h10, 1'b1, 32'hA1B2C3D4, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL classic_wr_lat got %0d want 1", lat); end
    wb0_classic(32'h10, 1'b0, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL classic_rd_lat got %0d want 1", lat); end
    checks++; if (rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL classic_rd_dat got %h want a1b2c3d4", rd); end
    word = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      cpu0_read(13'h10 + 13'(i), b);
      checks++;
      if (b !== word[31-8*i -: 8]) begin
        errors++; $display("FAIL cpu_rd_byte%0d got %h want %h", i, b, word[31-8*i -: 8]);
      end
    end
    @(posedge clk); #1; ca0 = 13'h0;
    repeat (2) @(negedge clk);
    checks++; if (cdo0 !== 8'hD4) begin errors++; $display("FAIL cpu_do_hold got %h want d4", cdo0); end
  endtask

  task automatic test_wait_states;
    logic exp;
    @(posedge clk); #1;
    adr1 = 32'h20; we1 = 1'b0; cti1 = CTI_CLASSIC; stb1 = 1'b1; cyc1 = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 3);
      checks++;
      if (ack1 !== exp) begin errors++; $display("FAIL ws2_ack_cyc%0d got %b want %b", c, ack1, exp); end
      if (c == 3) begin
        @(posedge clk); #1;
        stb1 = 1'b0; cyc1 = 1'b0;
      end
    end
    $display("wb ws2 read done");
  endtask

  task automatic test_burst;
    logic [31:0] rd;
    int lat;
    logic [7:0] ackv;
    logic [255:0] dv;
    logic [31:0] expd [4];
    int beat;
    expd[0] = 32'hC0DE07FF; expd[1] = 32'h10000000; expd[2] = 32'h10000001; expd[3] = 32'h10000002;
    wb0_classic(32'h1FFC, 1'b1, expd[0], 4'hF, rd, lat);
    for (int i = 0; i < 3; i++) wb0_classic(32'(4*i), 1'b1, expd[i+1], 4'hF, rd, lat);

    run_burst0(32'h1FFC, 8'b0000_1111, 4, ackv, dv);
    checks++; if (ackv[4:0] !== 5'b01111) begin errors++; $display("FAIL burst_acks got %b want 01111", ackv[4:0]); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dv[32*c +: 32] !== expd[c]) begin
        errors++; $display("FAIL burst_beat%0d got %h want %h", c, dv[32*c +: 32], expd[c]);
      end
    end

    run_burst0(32'h1FFC, 8'b0011_0011, 6, ackv, dv);
    checks++; if (ackv[6:0] !== 7'b0110011) begin errors++; $display("FAIL pause_acks got %b want 0110011", ackv[6:0]); end
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0 || c == 1 || c == 4 || c == 5) begin
        checks++;
        if (dv[32*c +: 32] !== expd[beat]) begin
          errors++; $display("FAIL pause_beat%0d got %h want %h", beat, dv[32*c +: 32], expd[beat]);
        end
        beat++;
      end
    end
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    int lat;
    logic [7:0] b;
    wb0_classic(32'h14, 1'b1, 32'h0, 4'hF, rd, lat);

    @(posedge clk); #1;
    adr0 = 32'h14; we0 = 1'b1; dati0 = 32'hFF000000; sel0 = 4'b1000; cti0 = CTI_CLASSIC;
    stb0 = 1'b1; cyc0 = 1'b1;
    @(posedge clk); #1;
    ca0 = 13'd20; cdi0 = 8'h11; cwe0 = 1'b1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL coll_ack got %b want 1", ack0); end
    @(posedge clk); #1;
    stb0 = 1'b0; cyc0 = 1'b0; we0 = 1'b0; cwe0 = 1'b0;
    @(negedge clk);
    checks++; if (coll0 !== 16'd1) begin errors++; $display("FAIL coll_cnt got %0d want 1", coll0); end
    cpu0_read(13'd20, b);
    checks++; if (b !== 8'hFF) begin errors++; $display("FAIL coll_byte got %h want ff", b); end

    @(posedge clk); #1;
    adr0 = 32'h14; we0 = 1'b1; dati0 = 32'h00EE0000; sel0 = 4'b0100; cti0 = CTI_CLASSIC;
    stb0 = 1'b1; cyc0 = 1'b1;
    @(posedge clk); #1;
    ca0 = 13'd22; cdi0 = 8'h22; cwe0 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    stb0 = 1'b0; cyc0 = 1'b0; we0 = 1'b0; cwe0 = 1'b0;
    @(negedge clk);
    checks++; if (coll0 !== 16'd1) begin errors++; $display("FAIL nocoll_cnt got %0d want 1", coll0); end
    wb0_classic(32'h14, 1'b0, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFFEE2200) begin errors++; $display("FAIL nocoll_word got %h want ffee2200", rd); end
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] rd;
    int lat;
    @(posedge clk); #1;
    adr0 = 32'h0; we0 = 1'b0; cti0 = CTI_INCR; stb0 = 1'b1; cyc0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL mid_burst_ack got %b want 1", ack0); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_async_ack got %b want 0", ack0); end
    checks++; if (dut0.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d want 0", dut0.state_q); end
    stb0 = 1'b0; cyc0 = 1'b0; cti0 = CTI_CLASSIC;
    @(negedge clk);
    rst_n = 1'b1;
    wb0_classic(32'h10, 1'b0, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL post_rst_lat got %0d want 1", lat); end
    checks++; if (rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL post_rst_dat got %h want a1b2c3d4", rd); end
    checks++; if (coll0 !== 16'd0) begin errors++; $display("FAIL post_rst_coll got %0d want 0", coll0); end
  endtask

  task automatic test_lanes2;
    int lat;
    @(posedge clk); #1;
    ca2 = 5'd1; cdi2 = 8'h5A; cwe2 = 1'b1;
    @(posedge clk); #1;
    ca2 = 5'd0; cdi2 = 8'h3C;
    @(posedge clk); #1;
    cwe2 = 1'b0; adr2 = 32'h0; we2 = 1'b0; cti2 = CTI_CLASSIC; stb2 = 1'b1; cyc2 = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack2) break;
      lat++;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL le2_lat got %0d want 1", lat); end
    checks++; if (dato2[15:8] !== 8'h5A) begin errors++; $display("FAIL le2_hi got %h want 5a", dato2[15:8]); end
    checks++; if (dato2[7:0] !== 8'h3C) begin errors++; $display("FAIL le2_lo got %h want 3c", dato2[7:0]); end
    @(posedge clk); #1;
    stb2 = 1'b0; cyc2 = 1'b0;
    $display("le2 read dat=%h", dato2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    adr0 = '0; dati0 = '0; sel0 = '0; stb0 = 0; cyc0 = 0; we0 = 0; cti0 = '0;
    ca0 = '0; cre0 = 0; cwe0 = 0; cdi0 = '0;
    adr1 = '0; dati1 = '0; sel1 = '0; stb1 = 0; cyc1 = 0; we1 = 0; cti1 = '0;
    ca1 = '0; cre1 = 0; cwe1 = 0; cdi1 = '0;
    adr2 = '0; dati2 = '0; sel2 = '0; stb2 = 0; cyc2 = 0; we2 = 0; cti2 = '0;
    ca2 = '0; cre2 = 0; cwe2 = 0; cdi2 = '0;
    #23 rst_n = 1'b1;

    test_reset();
    test_classic();
    test_wait_states();
    test_burst();
    test_collision();
    test_reset_mid_burst();
    test_lanes2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
